// File: rtl/fe_fetch_if.sv
// Fetch unit bus: run control, redirect, I-cache request/response and decode-side queue head.
// master = the fetch unit, slave = its environment (I-cache, decode, control).
interface fe_fetch_if #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned ILEN   = 32,
    parameter int unsigned QDEPTH = 4
) ();
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    // Control
    logic            run_en;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // I-cache request
    logic            ic_req_valid;
    logic [XLEN-1:0] ic_req_pc;
    logic            ic_req_ready;

    // I-cache response
    logic            ic_rsp_valid;
    logic [XLEN-1:0] ic_rsp_pc;
    logic [ILEN-1:0] ic_rsp_inst;
    logic            ic_rsp_fault;
    logic            ic_rsp_ready;

    // Decode side
    logic            inst_valid;
    logic [XLEN-1:0] inst_pc;
    logic [ILEN-1:0] inst_word;
    logic            inst_fault;
    logic            inst_ready;
    logic [CW-1:0]   q_count;

    modport master (
        input  run_en, redirect_valid, redirect_pc,
        output ic_req_valid, ic_req_pc,
        input  ic_req_ready,
        input  ic_rsp_valid, ic_rsp_pc, ic_rsp_inst, ic_rsp_fault,
        output ic_rsp_ready,
        output inst_valid, inst_pc, inst_word, inst_fault,
        input  inst_ready,
        output q_count
    );

    modport slave (
        output run_en, redirect_valid, redirect_pc,
        input  ic_req_valid, ic_req_pc,
        output ic_req_ready,
        output ic_rsp_valid, ic_rsp_pc, ic_rsp_inst, ic_rsp_fault,
        input  ic_rsp_ready,
        input  inst_valid, inst_pc, inst_word, inst_fault,
        output inst_ready,
        input  q_count
    );
endinterface

// File: rtl/fe_fetch_q.sv
// Decoupled fetch unit: up to MAX_OUT I-cache requests in flight, responses buffered in an
// in-order QDEPTH-entry queue. Credits (outstanding + occupancy) guarantee the queue never
// overflows, so the response channel is always ready. Redirects flush the queue and turn every
// request still in flight into a response that must be discarded.
module fe_fetch_q #(
    parameter int unsigned    XLEN     = 64,
    parameter int unsigned    ILEN     = 32,
    parameter int unsigned    QDEPTH   = 4,
    parameter int unsigned    MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic        clk,
    input logic        rst,
    fe_fetch_if.master bus
);
    localparam int unsigned PW   = $clog2(QDEPTH);
    localparam int unsigned CW   = $clog2(QDEPTH + 1);
    localparam int unsigned OW   = $clog2(MAX_OUT + 1);
    localparam int unsigned STEP = ILEN / 8;

    // Architectural state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [OW-1:0]   out_q, out_d;
    logic [OW-1:0]   drop_q, drop_d;
    logic            halted_q, halted_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Queue storage; validity is tracked by count_q, so the payload needs no reset
    logic [XLEN-1:0] pc_mem_q    [QDEPTH];
    logic [ILEN-1:0] inst_mem_q  [QDEPTH];
    logic            fault_mem_q [QDEPTH];

    logic req_valid;
    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;
    logic head_valid;

    // Issue gating: run permission, no redirect, not halted, and both credit limits
    always_comb begin
        req_valid = ~rst & bus.run_en & ~bus.redirect_valid & ~halted_q
                  & (32'(out_q) < MAX_OUT)
                  & ((32'(out_q) + 32'(count_q)) < QDEPTH);
        req_fire   = req_valid & bus.ic_req_ready;
        rsp_fire   = ~rst & bus.ic_rsp_valid;
        head_valid = (count_q != '0);
        // A response is kept only when nothing stale is ahead of it and no redirect is flushing
        push       = rsp_fire & ~bus.redirect_valid & (drop_q == '0);
        pop        = head_valid & bus.inst_ready & ~bus.redirect_valid;
    end

    // Next-state for PC, credit counters, halt flag and queue pointers
    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q;
        drop_d   = drop_q;
        halted_d = halted_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        out_d = out_q + OW'(req_fire) - OW'(rsp_fire);

        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            halted_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            // Everything still in flight after this cycle's response belongs to the old path
            drop_d   = out_q - OW'(rsp_fire);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(STEP);
            end
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (push && bus.ic_rsp_fault) begin
                halted_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            halted_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            halted_q <= halted_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue payload write at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= bus.ic_rsp_pc;
            inst_mem_q[wr_ptr_q]  <= bus.ic_rsp_inst;
            fault_mem_q[wr_ptr_q] <= bus.ic_rsp_fault;
        end
    end

    // Outputs; head payload is forced to zero when the queue is empty
    always_comb begin
        bus.ic_req_valid = req_valid;
        bus.ic_req_pc    = pc_q;
        bus.ic_rsp_ready = ~rst;
        bus.inst_valid   = head_valid;
        bus.inst_pc      = head_valid ? pc_mem_q[rd_ptr_q] : '0;
        bus.inst_word    = head_valid ? inst_mem_q[rd_ptr_q] : '0;
        bus.inst_fault   = head_valid & fault_mem_q[rd_ptr_q];
        bus.q_count      = count_q;
    end
endmodule

// File: tb/tb_fe_fetch_q.sv
// Self-checking bench for fe_fetch_q: a queue-based I-cache with variable latency plus a
// transaction-level reference model (in-flight list with stale flags, expected fetch queue).
module tb_fe_fetch_q;
    localparam int unsigned QD = 4;
    localparam int unsigned MO = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    typedef struct {
        logic [63:0] pc;
        int          due;
    } icq_t;

    logic clk = 1'b0;
    logic rst;

    fe_fetch_if #(.XLEN(64), .ILEN(32), .QDEPTH(QD)) bus ();

    fe_fetch_q #(
        .XLEN    (64),
        .ILEN    (32),
        .QDEPTH  (QD),
        .MAX_OUT (MO),
        .RESET_PC(64'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int pops  = 0;

    // Reference model
    ent_t        m_q[$];
    logic [63:0] infl_pc[$];
    bit          infl_stale[$];
    logic [63:0] m_pc;
    bit          m_halted;
    logic [63:0] fault_pc;

    // I-cache model
    icq_t icq[$];
    int   last_due;

    // Stimulus knobs
    int          p_run = 100, p_rdy = 100, p_ird = 100, p_redir = 0;
    int          lat_lo = 1, lat_hi = 1;
    bit          redir_now = 0;
    logic [63:0] redir_pc_n;

    function automatic logic [31:0] inst_of(logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        infl_pc.delete();
        infl_stale.delete();
        icq.delete();
        m_pc     = 64'h0;
        m_halted = 0;
        last_due = 0;
    endtask

    task automatic set_inputs();
        bus.run_en       = ($urandom_range(99) < p_run);
        bus.ic_req_ready = ($urandom_range(99) < p_rdy);
        bus.inst_ready   = ($urandom_range(99) < p_ird);
        if (redir_now || ($urandom_range(999) < p_redir)) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = redir_now ? redir_pc_n : ({32'h0, $urandom} & ~64'h3);
        end else begin
            bus.redirect_valid = 1'b0;
        end
        redir_now = 0;
        if (icq.size() > 0 && icq[0].due <= cyc) begin
            icq_t r;
            r = icq.pop_front();
            bus.ic_rsp_valid = 1'b1;
            bus.ic_rsp_pc    = r.pc;
            bus.ic_rsp_inst  = inst_of(r.pc);
            bus.ic_rsp_fault = (r.pc == fault_pc);
        end else begin
            bus.ic_rsp_valid = 1'b0;
            bus.ic_rsp_pc    = 64'h0;
            bus.ic_rsp_inst  = 32'h0;
            bus.ic_rsp_fault = 1'b0;
        end
    endtask

    // One clock: drive, check mid-cycle, advance the model after the edge
    task automatic cycle();
        bit          exp_rv, rf, pf, ff, rd, st;
        logic [63:0] rd_pc, rsp_pc;
        logic        rsp_fault;
        set_inputs();
        #3;
        exp_rv = bus.run_en && !bus.redirect_valid && !m_halted && (infl_pc.size() < MO)
               && (infl_pc.size() + m_q.size() < QD);
        chk("req_valid", 64'(bus.ic_req_valid), 64'(exp_rv));
        if (exp_rv) chk("req_pc", bus.ic_req_pc, m_pc);
        chk("q_count", 64'(bus.q_count), 64'(m_q.size()));
        chk("inst_valid", 64'(bus.inst_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("inst_pc", bus.inst_pc, m_q[0].pc);
            chk("inst_word", 64'(bus.inst_word), 64'(m_q[0].inst));
            chk("inst_fault", 64'(bus.inst_fault), 64'(m_q[0].fault));
        end
        chk("rsp_ready", 64'(bus.ic_rsp_ready), 64'h1);
        rf        = bus.ic_req_valid && bus.ic_req_ready;
        pf        = bus.ic_rsp_valid;
        ff        = bus.inst_valid && bus.inst_ready;
        rd        = bus.redirect_valid;
        rd_pc     = bus.redirect_pc;
        rsp_pc    = bus.ic_rsp_pc;
        rsp_fault = bus.ic_rsp_fault;
        @(posedge clk);
        #1;
        if (ff && !rd) begin
            void'(m_q.pop_front());
            pops++;
        end
        if (pf) begin
            void'(infl_pc.pop_front());
            st = infl_stale.pop_front();
            if (!st && !rd) begin
                m_q.push_back('{pc: rsp_pc, inst: inst_of(rsp_pc), fault: rsp_fault});
                if (rsp_fault) m_halted = 1;
            end
        end
        if (rd) begin
            m_q.delete();
            foreach (infl_stale[i]) infl_stale[i] = 1;
            m_halted = 0;
            m_pc     = rd_pc;
        end
        if (rf) begin
            int due;
            infl_pc.push_back(m_pc);
            infl_stale.push_back(0);
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due < last_due) due = last_due;
            last_due = due;
            icq.push_back('{pc: m_pc, due: due});
            m_pc = m_pc + 64'd4;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect(input logic [63:0] pc);
        redir_now  = 1;
        redir_pc_n = pc;
        cycle();
    endtask

    // Asynchronous reset: outputs must settle with no clock edge
    task automatic do_reset();
        bus.run_en         = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.ic_rsp_valid   = 1'b0;
        bus.inst_ready     = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_req_valid", 64'(bus.ic_req_valid), 64'h0);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
        chk("rst_inst_pc", bus.inst_pc, 64'h0);
        chk("rst_inst_word", 64'(bus.inst_word), 64'h0);
        chk("rst_inst_fault", 64'(bus.inst_fault), 64'h0);
        chk("rst_q_count", 64'(bus.q_count), 64'h0);
        chk("rst_rsp_ready", 64'(bus.ic_rsp_ready), 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        int p0;
        fault_pc           = 64'h1;
        bus.run_en         = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.ic_req_ready   = 1'b0;
        bus.ic_rsp_valid   = 1'b0;
        bus.ic_rsp_pc      = 64'h0;
        bus.ic_rsp_inst    = 32'h0;
        bus.ic_rsp_fault   = 1'b0;
        bus.inst_ready     = 1'b0;
        model_clear();
        do_reset();

        // Streaming at one instruction per cycle
        run(10);
        p0 = pops;
        run(20);
        chk("throughput", 64'(pops - p0), 64'd20);

        // Backpressure fills the queue and stalls issue, then drains in order
        p_ird = 0;
        run(10);
        chk("bp_full", 64'(bus.q_count), 64'(QD));
        p_ird = 100;
        run(20);

        // Redirect with two requests in flight and slow responses
        lat_lo = 3; lat_hi = 3;
        run(6);
        redirect(64'h1000);
        run(15);

        // Redirect in steady state: coincides with a response fire and an inst fire
        lat_lo = 1; lat_hi = 1;
        run(8);
        redirect(64'h2000);
        run(10);

        // Faulting fetch halts issue until a redirect
        do_reset();
        fault_pc = 64'h8;
        run(15);
        fault_pc = 64'h1;
        redirect(64'h40);
        run(10);

        // PC wraps modulo 2^64
        redirect(64'hFFFF_FFFF_FFFF_FFF8);
        run(10);

        // Randomized traffic with occasional redirects
        do_reset();
        p_run = 80; p_rdy = 70; p_ird = 60; p_redir = 30;
        lat_lo = 1; lat_hi = 4;
        run(400);

        // Reset in the middle of traffic
        do_reset();
        p_redir = 0;
        run(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
